joypad_responder: RTL

JOYPAD_RESPONDER -- requirements
Module: joypad_responder

---
 rtl/jp_pkg.sv | 20 ++
 rtl/jp_sync_filter.sv | 39 +++
 rtl/joypad_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/jp_pkg.sv
// rtl/jp_pkg.sv - joypad responder shared constants and FSM encoding
package jp_pkg;

  localparam int JP_BTN_A      = 0;
  localparam int JP_BTN_B      = 1;
  localparam int JP_BTN_SELECT = 2;
  localparam int JP_BTN_START  = 3;
  localparam int JP_BTN_UP     = 4;
  localparam int JP_BTN_DOWN   = 5;
  localparam int JP_BTN_LEFT   = 6;
  localparam int JP_BTN_RIGHT  = 7;
  localparam int JP_NUM_BTNS   = 8;

  typedef enum logic [1:0] {
    JP_LOAD  = 2'd0,
    JP_SHIFT = 2'd1,
    JP_EMPTY = 2'd2
  } jp_state_t;

endpackage

// File: rtl/jp_sync_filter.sv
// rtl/jp_sync_filter.sv - one-bit pin synchronizer followed by a level filter
module jp_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_in,
  input  logic nres_in,
  input  logic pin,
  output logic filtered
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0]             cnt_q;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // The output follows the synchronized level only after FILTER_LEN equal samples in a row.
  always_ff @(posedge clk_in) begin
    if (!nres_in) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filtered <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      if (sync_bit != filtered) begin
        if (cnt_q == 4'(FILTER_LEN - 1)) begin
          filtered <= sync_bit;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/joypad_responder.sv
// rtl/joypad_responder.sv - serial joypad responder answering console latch/clock polls
module joypad_responder
  import jp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic       clk_in,
  input  logic       nres_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  input  logic [7:0] buttons_in,
  output logic       jp_data_out,
  output logic       poll_out,
  output logic [3:0] bit_idx_out
);

  localparam logic [3:0] IDX_FULL = 4'(JP_NUM_BTNS);

  logic latch_f, latch_d, clk_f, clk_d;
  logic latch_fall, clk_rise;

  jp_state_t              state_q, state_d;
  logic [JP_NUM_BTNS-1:0] shreg_q, shreg_d;
  logic [3:0]             idx_d;
  logic                   data_d, poll_d;

  jp_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_latch_filt (
    .clk_in   (clk_in),
    .nres_in  (nres_in),
    .pin      (jp_latch_in),
    .filtered (latch_f)
  );

  jp_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_in   (clk_in),
    .nres_in  (nres_in),
    .pin      (jp_clk_in),
    .filtered (clk_f)
  );

  assign latch_fall = latch_d & ~latch_f;
  assign clk_rise   = clk_f & ~clk_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = bit_idx_out;
    data_d  = jp_data_out;
    poll_d  = 1'b0;
    // Latch level overrides everything, including a clock edge in the same cycle.
    if (latch_f) begin
      state_d = JP_LOAD;
      shreg_d = buttons_in;
      idx_d   = 4'd0;
      data_d  = ~buttons_in[JP_BTN_A];
    end else begin
      case (state_q)
        JP_LOAD: begin
          if (latch_fall) begin
            state_d = JP_SHIFT;
            poll_d  = 1'b1;
          end
        end
        JP_SHIFT: begin
          // bit_idx_out at 8 in SHIFT is the post-reset idle state: edges ignored.
          if (clk_rise && bit_idx_out != IDX_FULL) begin
            shreg_d = {1'b0, shreg_q[JP_NUM_BTNS-1:1]};
            idx_d   = bit_idx_out + 4'd1;
            if (bit_idx_out == IDX_FULL - 4'd1) begin
              state_d = JP_EMPTY;
              data_d  = 1'b0;
            end else begin
              data_d = ~shreg_q[1];
            end
          end
        end
        JP_EMPTY: begin
          data_d = 1'b0;
        end
        default: begin
          state_d = JP_SHIFT;
          idx_d   = IDX_FULL;
          data_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!nres_in) begin
      state_q     <= JP_SHIFT;
      shreg_q     <= '0;
      bit_idx_out <= IDX_FULL;
      jp_data_out <= 1'b1;
      poll_out    <= 1'b0;
      latch_d     <= 1'b0;
      clk_d       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_idx_out <= idx_d;
      jp_data_out <= data_d;
      poll_out    <= poll_d;
      latch_d     <= latch_f;
      clk_d       <= clk_f;
    end
  end

endmodule
